// File: rtl/antidiff_sequencer.sv
// -----------------------------------------------------------------------------
// antidiff_sequencer
// Control-path sequencer for the pipelined multi-column antidiff (cumulative-sum)
// operator. Data runs directly between source, operator and sink; this block
// only decides when the operator is enabled, cleared, and when its result is
// presented to the sink.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   clear       synchronous abort: drop work, clear operator, restart frame
//   in_valid    source has an input vector on the operator's in bus
//   in_ready    vector accepted on a cycle where in_valid && in_ready
//   out_valid   operator out bus holds a finished result
//   out_ready   sink takes the result on a cycle where out_valid && out_ready
//   op_en       operator enable, one-cycle pulse per accepted vector
//   op_reset    operator synchronous reset (active-high)
//   sample_idx  index of the current/next sample within the frame
//   frame_last  with out_valid: this result is sample FRAME_LEN-1
//   busy        state != IDLE
//   state_dbg   current FSM state encoding
//
// Handshake semantics: a transfer happens on every rising edge where valid and
// ready are both high. Valid never depends on ready. Once out_valid is raised it
// stays high (and the result stays stable) until the transfer or a clear/reset.
// in_ready is the only combinational output (state decode & !clear).
// -----------------------------------------------------------------------------
module antidiff_sequencer #(
    parameter int COLUMNS   = 1,
    parameter int FRAME_LEN = 256,
    parameter int IDX_BITS  = $clog2(FRAME_LEN)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                op_en,
    output logic                op_reset,
    output logic [IDX_BITS-1:0] sample_idx,
    output logic                frame_last,
    output logic                busy,
    output logic [2:0]          state_dbg
);

    localparam logic [2:0] ST_CLR   = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_CARRY = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;

    // RUN lasts COLUMNS-1 cycles; the counter holds the cycles left after the
    // current one, so it is loaded with COLUMNS-2 on entry.
    localparam int               CNT_W    = (COLUMNS > 2) ? $clog2(COLUMNS - 1) : 1;
    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'((COLUMNS >= 2) ? (COLUMNS - 2) : 0);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_LEN - 1);

    logic [2:0]          state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [IDX_BITS-1:0] idx_n;

    assign state_dbg = state_q;
    assign in_ready  = (state_q == ST_IDLE) && !clear;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = sample_idx;
        if (clear) begin
            state_n = ST_CLR;
            idx_n   = '0;
        end else begin
            case (state_q)
                ST_CLR:   state_n = ST_IDLE;
                ST_IDLE:  if (in_valid) state_n = ST_ISSUE;
                ST_ISSUE: begin
                    if (COLUMNS == 1) begin
                        state_n = ST_CARRY;
                    end else begin
                        state_n = ST_RUN;
                        cnt_n   = RUN_LOAD;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == '0) state_n = ST_CARRY;
                    else             cnt_n   = cnt_q - CNT_W'(1);
                end
                ST_CARRY: state_n = ST_OUT;
                ST_OUT: begin
                    if (out_ready) begin
                        // The end of a frame goes back through CLR so the
                        // operator's running sum restarts from zero.
                        if (sample_idx == LAST_IDX) begin
                            idx_n   = '0;
                            state_n = ST_CLR;
                        end else begin
                            idx_n   = sample_idx + IDX_BITS'(1);
                            state_n = ST_IDLE;
                        end
                    end
                end
                default:  state_n = ST_CLR;
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe and carry no path from in_valid/out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CLR;
            cnt_q      <= '0;
            sample_idx <= '0;
            op_reset   <= 1'b1;
            op_en      <= 1'b0;
            out_valid  <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            sample_idx <= idx_n;
            op_reset   <= (state_n == ST_CLR);
            op_en      <= (state_n == ST_ISSUE);
            out_valid  <= (state_n == ST_OUT);
            frame_last <= (state_n == ST_OUT) && (idx_n == LAST_IDX);
            busy       <= (state_n != ST_IDLE);
        end
    end

endmodule
